// File: rtl/gpsdo_pkg.sv
// ---------------------------------------------------------------------------
// gpsdo_pkg
// Shared definitions for the GPSDO loop control blocks: the lock-acquisition
// state encoding, the PID gain-set encodings and the default loop constants
// (zero-error phase target, error windows, qualification counts, PPS timeout).
// No ports; imported with "import gpsdo_pkg::*;".
// ---------------------------------------------------------------------------
package gpsdo_pkg;

   localparam int PHASE_W = 24;
   localparam int ERR_W   = 16;
   localparam int CNT_W   = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACQUIRE  = 3'd1,
      ST_TRACK    = 3'd2,
      ST_LOCKED   = 3'd3,
      ST_HOLDOVER = 3'd4
   } loop_state_t;

   localparam logic [1:0] GAIN_ACQ   = 2'd0;
   localparam logic [1:0] GAIN_TRACK = 2'd1;
   localparam logic [1:0] GAIN_LOCK  = 2'd2;

   localparam int unsigned DEF_TARGET      = 1_000_000;
   localparam int unsigned DEF_TRACK_WIN   = 1000;
   localparam int unsigned DEF_LOCK_WIN    = 100;
   localparam int unsigned DEF_UNLOCK_WIN  = 500;
   localparam int unsigned DEF_ACQ_CNT     = 4;
   localparam int unsigned DEF_LOCK_CNT    = 16;
   localparam int unsigned DEF_PPS_TIMEOUT = 12_000_000;

endpackage

// File: rtl/phase_err_sat.sv
// ---------------------------------------------------------------------------
// phase_err_sat
// Combinational phase-error path: subtracts the zero-error target from the
// raw phase count, clamps the 25-bit signed difference into 16-bit signed
// range and provides its magnitude for the lock window comparisons.
//
// Ports:
//   i_phase  - raw unsigned phase count
//   o_err    - clamped signed error, [-32768, 32767]
//   o_abs    - |o_err| as unsigned (32768 is representable)
// ---------------------------------------------------------------------------
module phase_err_sat
   import gpsdo_pkg::*;
#(
   parameter int unsigned TARGET = DEF_TARGET
)(
   input  logic [PHASE_W-1:0]      i_phase,
   output logic signed [ERR_W-1:0] o_err,
   output logic [ERR_W-1:0]        o_abs
);

   localparam logic [PHASE_W:0] TARGET_V = (PHASE_W+1)'(TARGET);

   logic signed [PHASE_W:0] w_err25;

   // Both operands fit in 25 bits, so the modular difference is the exact
   // two's-complement error.
   assign w_err25 = $signed({1'b0, i_phase} - TARGET_V);

   always_comb begin
      if (w_err25 > 25'sd32767) begin
         o_err = 16'sh7FFF;
      end else if (w_err25 < -25'sd32768) begin
         o_err = 16'sh8000;
      end else begin
         o_err = w_err25[ERR_W-1:0];
      end
      // Negating -32768 wraps to 0x8000, which read as unsigned is 32768.
      o_abs = o_err[ERR_W-1] ? (~o_err + 1'b1) : o_err;
   end

endmodule

// File: rtl/pid_loop_sequencer.sv
// ---------------------------------------------------------------------------
// pid_loop_sequencer
// Sequences the GPSDO phase-locked loop around the PID calculator. Each
// accepted phase measurement becomes a saturated signed error, a
// lock-acquisition FSM picks the PID gain set and integrator behaviour, and a
// start/done handshake paces the PID updates.
//
// Optional feature macro: PID_SEQ_HOLDOVER_EN enables the PPS timeout counter
// and the HOLDOVER state; without it Holdover is tied low.
//
// Ports:
//   CLK_SYS        - system clock
//   CLK_RST        - asynchronous active-low reset
//   Measure_Phase  - raw phase count, valid with Measure_Done
//   Measure_Done   - one-cycle measurement strobe
//   Pid_Done       - one-cycle PID completion strobe
//   Pid_Start      - one-cycle PID update request
//   Pid_Error      - saturated error of the last accepted sample
//   Pid_Gain_Sel   - gain set (ACQ/TRACK/LOCK)
//   Pid_Int_Clr    - one-cycle integrator clear
//   Pid_Int_Hold   - integrator freeze level
//   Led_Lock       - high in LOCKED
//   Holdover       - high in HOLDOVER
//   Overrun        - sticky dropped-sample flag
// ---------------------------------------------------------------------------
module pid_loop_sequencer
   import gpsdo_pkg::*;
#(
   parameter int unsigned TARGET      = DEF_TARGET,
   parameter int unsigned TRACK_WIN   = DEF_TRACK_WIN,
   parameter int unsigned LOCK_WIN    = DEF_LOCK_WIN,
   parameter int unsigned UNLOCK_WIN  = DEF_UNLOCK_WIN,
   parameter int unsigned ACQ_CNT     = DEF_ACQ_CNT,
   parameter int unsigned LOCK_CNT    = DEF_LOCK_CNT,
   parameter int unsigned PPS_TIMEOUT = DEF_PPS_TIMEOUT
)(
   input  logic                    CLK_SYS,
   input  logic                    CLK_RST,
   input  logic [PHASE_W-1:0]      Measure_Phase,
   input  logic                    Measure_Done,
   input  logic                    Pid_Done,
   output logic                    Pid_Start,
   output logic signed [ERR_W-1:0] Pid_Error,
   output logic [1:0]              Pid_Gain_Sel,
   output logic                    Pid_Int_Clr,
   output logic                    Pid_Int_Hold,
   output logic                    Led_Lock,
   output logic                    Holdover,
   output logic                    Overrun
);

   localparam logic [ERR_W-1:0] TRACK_LIM  = ERR_W'(TRACK_WIN);
   localparam logic [ERR_W-1:0] LOCK_LIM   = ERR_W'(LOCK_WIN);
   localparam logic [ERR_W-1:0] UNLOCK_LIM = ERR_W'(UNLOCK_WIN);
   localparam logic [CNT_W-1:0] ACQ_N      = CNT_W'(ACQ_CNT);
   localparam logic [CNT_W-1:0] LOCK_N     = CNT_W'(LOCK_CNT);

   loop_state_t              r_state;
   loop_state_t              w_state_nxt;
   logic [CNT_W-1:0]         r_cnt;
   logic [CNT_W-1:0]         w_cnt_nxt;
   logic [CNT_W-1:0]         w_cnt_inc;
   logic                     w_clr_nxt;
   logic [1:0]               w_gain_nxt;
   logic [PHASE_W-1:0]       r_phase;
   logic                     r_pend1;
   logic                     r_pend2;
   logic                     r_busy;
   logic                     r_start;
   logic signed [ERR_W-1:0]  r_error;
   logic [1:0]               r_gain;
   logic                     r_int_clr;
   logic                     r_int_hold;
   logic                     r_led;
   logic                     r_hold;
   logic                     r_overrun;
   logic signed [ERR_W-1:0]  w_err;
   logic [ERR_W-1:0]         w_abs;
   logic                     w_done_ok;
   logic                     w_accept;
   logic                     w_drop;
   logic                     w_timeout;
   logic                     w_in_track;
   logic                     w_in_lock;
   logic                     w_over_unlock;

   phase_err_sat #(
      .TARGET (TARGET)
   ) u_err (
      .i_phase (r_phase),
      .o_err   (w_err),
      .o_abs   (w_abs)
   );

   // Pid_Done only counts once Pid_Start has actually been issued; a Done
   // landing in the same cycle as Measure_Done frees the slot for that sample.
   assign w_done_ok = Pid_Done && r_busy && !r_pend1 && !r_pend2;
   assign w_accept  = Measure_Done && (!r_busy || w_done_ok);
   assign w_drop    = Measure_Done && r_busy && !w_done_ok;

   assign w_in_track    = (w_abs <= TRACK_LIM);
   assign w_in_lock     = (w_abs <= LOCK_LIM);
   assign w_over_unlock = (w_abs > UNLOCK_LIM);
   assign w_cnt_inc     = r_cnt + 1'b1;

`ifdef PID_SEQ_HOLDOVER_EN
   localparam int TMO_W = $clog2(PPS_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(PPS_TIMEOUT);

   logic [TMO_W-1:0] r_tmo;

   // Cycles since the last measurement strobe (dropped ones included),
   // parked at the timeout value.
   always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
      if (!CLK_RST) begin
         r_tmo <= '0;
      end else if (Measure_Done) begin
         r_tmo <= '0;
      end else if (r_tmo != TMO_MAX) begin
         r_tmo <= r_tmo + 1'b1;
      end
   end

   assign w_timeout = (r_tmo == TMO_MAX) &&
                      ((r_state == ST_ACQUIRE) || (r_state == ST_TRACK) ||
                       (r_state == ST_LOCKED));
`else
   assign w_timeout = 1'b0;
`endif

   // Next-state logic: a captured sample is evaluated one edge after capture;
   // otherwise only the PPS timeout can move the loop.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clr_nxt   = 1'b0;
      if (r_pend1) begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_ACQUIRE;
               w_clr_nxt   = 1'b1;
            end
            ST_ACQUIRE: begin
               if (!w_in_track) begin
                  w_cnt_nxt = '0;
               end else if (w_cnt_inc >= ACQ_N) begin
                  w_state_nxt = ST_TRACK;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
            ST_TRACK: begin
               if (!w_in_track) begin
                  w_state_nxt = ST_ACQUIRE;
                  w_clr_nxt   = 1'b1;
               end else if (!w_in_lock) begin
                  w_cnt_nxt = '0;
               end else if (w_cnt_inc >= LOCK_N) begin
                  w_state_nxt = ST_LOCKED;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
            ST_LOCKED: begin
               if (!w_in_track) begin
                  w_state_nxt = ST_ACQUIRE;
                  w_clr_nxt   = 1'b1;
               end else if (w_over_unlock) begin
                  w_state_nxt = ST_TRACK;
               end
            end
            ST_HOLDOVER: begin
               if (w_in_track) begin
                  w_state_nxt = ST_TRACK;
               end else begin
                  w_state_nxt = ST_ACQUIRE;
                  w_clr_nxt   = 1'b1;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end else if (w_timeout) begin
         w_state_nxt = ST_HOLDOVER;
      end
      if (w_state_nxt != r_state) begin
         w_cnt_nxt = '0;
      end

      // HOLDOVER keeps whichever gain set was active when the pulses stopped.
      case (w_state_nxt)
         ST_TRACK:    w_gain_nxt = GAIN_TRACK;
         ST_LOCKED:   w_gain_nxt = GAIN_LOCK;
         ST_HOLDOVER: w_gain_nxt = r_gain;
         default:     w_gain_nxt = GAIN_ACQ;
      endcase
   end

   // State, qualification counter and state-decoded outputs move together.
   always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
      if (!CLK_RST) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_gain     <= GAIN_ACQ;
         r_int_clr  <= 1'b0;
         r_int_hold <= 1'b0;
         r_led      <= 1'b0;
         r_hold     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_gain     <= w_gain_nxt;
         r_int_clr  <= w_clr_nxt;
         r_int_hold <= (w_state_nxt == ST_ACQUIRE) || (w_state_nxt == ST_HOLDOVER);
         r_led      <= (w_state_nxt == ST_LOCKED);
         r_hold     <= (w_state_nxt == ST_HOLDOVER);
      end
   end

   // Sample capture and the PID handshake pipeline: capture, evaluate, start.
   always_ff @(posedge CLK_SYS or negedge CLK_RST) begin
      if (!CLK_RST) begin
         r_phase   <= '0;
         r_pend1   <= 1'b0;
         r_pend2   <= 1'b0;
         r_start   <= 1'b0;
         r_busy    <= 1'b0;
         r_error   <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_pend1 <= w_accept;
         r_pend2 <= r_pend1;
         r_start <= r_pend2;
         if (w_accept) begin
            r_phase <= Measure_Phase;
            r_busy  <= 1'b1;
         end else if (w_done_ok) begin
            r_busy  <= 1'b0;
         end
         if (r_pend1) begin
            r_error <= w_err;
         end
         if (w_drop) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign Pid_Start    = r_start;
   assign Pid_Error    = r_error;
   assign Pid_Gain_Sel = r_gain;
   assign Pid_Int_Clr  = r_int_clr;
   assign Pid_Int_Hold = r_int_hold;
   assign Led_Lock     = r_led;
   assign Holdover     = r_hold;
   assign Overrun      = r_overrun;

endmodule

// File: doc/pid_loop_sequencer.md
# pid_loop_sequencer

Sequences the GPSDO phase-locked loop around the PID datapath. Each phase measurement is turned into a saturated signed error, and the block runs a start/done handshake with the PID calculator. It selects the PID gain set and integrator behaviour from a lock-acquisition state machine, and drives the lock LED and holdover status. It sits between the phase measurement unit and the PID/PWM stage, all in the CLK_SYS domain.

## Interface
- TARGET, 1_000_000: phase count that corresponds to zero error.
- TRACK_WIN, 1000: |error| limit for ACQUIRE→TRACK; exceeding it forces ACQUIRE.
- LOCK_WIN, 100: |error| limit for counting toward LOCKED.
- UNLOCK_WIN, 500: |error| above which LOCKED drops to TRACK.
- ACQ_CNT, 4: consecutive in-window samples needed for ACQUIRE→TRACK.
- LOCK_CNT, 16: consecutive in-window samples needed for TRACK→LOCKED.
- PPS_TIMEOUT, 12_000_000: CLK_SYS cycles with no Measure_Done before HOLDOVER.
- CLK_SYS in 1: system clock.
- CLK_RST in 1: reset, asynchronous, active-low.
- Measure_Phase in 24: raw unsigned phase count; valid while Measure_Done is high.
- Measure_Done in 1: one-cycle pulse, synchronous to CLK_SYS.
- Pid_Done in 1: one-cycle pulse from the PID calculator when its update is complete.
- Pid_Start out 1: one-cycle pulse requesting a PID update.
- Pid_Error out 16 signed: saturated error; stable from capture until the next accepted sample.
- Pid_Gain_Sel out 2: 0 = ACQ, 1 = TRACK, 2 = LOCK; 3 is never driven.
- Pid_Int_Clr out 1: one-cycle pulse that clears the PID integrator.
- Pid_Int_Hold out 1: level; freezes the integrator.
- Led_Lock out 1: high only in LOCKED.
- Holdover out 1: high only in HOLDOVER.
- Overrun out 1: sticky flag for a dropped sample; cleared only by reset.

## Operation
- States: IDLE, ACQUIRE, TRACK, LOCKED, HOLDOVER.
- Reset values: all outputs 0, Pid_Gain_Sel = 0, state IDLE, counters 0.
- Error: err25 = Measure_Phase − TARGET, signed 25-bit. It is clamped to [−32768, 32767] before it is used for window checks and for Pid_Error.
- Windows compare |err| using the clamped value. A sample exactly on a limit counts as in-window (≤).
- IDLE: the first accepted sample moves to ACQUIRE and pulses Pid_Int_Clr.
- ACQUIRE: Pid_Int_Hold = 1, gain ACQ. ACQ_CNT consecutive samples with |e| ≤ TRACK_WIN move to TRACK. Any out-of-window sample zeroes the counter.
- TRACK: Pid_Int_Hold = 0, gain TRACK.
  - LOCK_CNT consecutive samples with |e| ≤ LOCK_WIN move to LOCKED.
  - |e| > TRACK_WIN moves to ACQUIRE and pulses Pid_Int_Clr.
- LOCKED: gain LOCK.
  - |e| > TRACK_WIN moves to ACQUIRE and pulses Pid_Int_Clr.
  - Otherwise, |e| > UNLOCK_WIN moves to TRACK.
  - Otherwise, stay in LOCKED.
- Consecutive counters reset on every state change.
- Timeout counter: cleared by every Measure_Done; saturates at PPS_TIMEOUT.
- HOLDOVER entry: reaching PPS_TIMEOUT in ACQUIRE, TRACK or LOCKED enters HOLDOVER.
- HOLDOVER behaviour: Pid_Int_Hold = 1, Pid_Gain_Sel keeps its last value, no Pid_Start, Pid_Error frozen.
- HOLDOVER exit: the next sample moves to TRACK if |e| ≤ TRACK_WIN. Otherwise it moves to ACQUIRE and pulses Pid_Int_Clr. That sample is processed normally.
- Handshake: busy runs from Pid_Start until Pid_Done.
  - Measure_Done while busy: the sample is dropped, Overrun is set, and state and Pid_Error are unchanged. The timeout counter is still cleared.
  - Pid_Done and Measure_Done in the same cycle: the Done is taken first and the sample is accepted.
  - Pid_Done while not busy is ignored.

## Timing
- Edge k (Measure_Done high): Measure_Phase is registered.
- Edge k+1: Pid_Error, state, Pid_Gain_Sel, Pid_Int_Hold, Led_Lock, Holdover and Pid_Int_Clr update together.
- Edge k+2: Pid_Start is high for one cycle, with the updated gain already stable.
- Samples arriving at edge k+1 or k+2 count as busy and are dropped.
- HOLDOVER is asserted on the edge after the timeout counter reaches PPS_TIMEOUT.
- Reset mid-handshake: everything returns to reset values immediately. A late Pid_Done after reset is ignored.

## Configuration
- PID_SEQ_HOLDOVER_EN defined: timeout counter and HOLDOVER state as described.
- PID_SEQ_HOLDOVER_EN undefined: no timeout counter, Holdover tied to 0, HOLDOVER unreachable. The loop stays in its last state indefinitely when pulses stop.

## Structure
- Shared package gpsdo_pkg holds:
  - the state enum (loop_state_t);
  - gain-select encodings GAIN_ACQ, GAIN_TRACK, GAIN_LOCK;
  - default window, count and TARGET constants.
- One sub-module, phase_err_sat: combinational subtract, clamp and absolute value. It outputs the clamped error and |e|.

## Test plan
- Reset, then Measure_Phase = 1_000_050 → Pid_Int_Clr pulse, ACQUIRE, Pid_Error = 50, Pid_Start two edges after Done, Pid_Gain_Sel = 0.
- Phase 1_040_000 → Pid_Error = 32767; phase 900_000 → Pid_Error = −32768; both give ACQUIRE with the counter at 0.
- 4 samples at e = 1000 → TRACK (gain 1). 16 samples at e = −100 → LOCKED (Led_Lock = 1, gain 2). e = 600 → TRACK. e = 5000 → ACQUIRE with a Pid_Int_Clr pulse.
- Withhold Pid_Done and send a second Measure_Done (e = 30) → dropped, Overrun = 1, Pid_Error unchanged. Pid_Done and the next Done in the same cycle → accepted.
- PPS_TIMEOUT = 1000, LOCKED, no Done for 1000 cycles → Holdover = 1, Led_Lock = 0, no Pid_Start. The next sample e = 20 → TRACK, Holdover = 0.
- Assert CLK_RST between Pid_Start and Pid_Done → all outputs 0, IDLE. A stray Pid_Done is ignored, and the next sample behaves like the first.
